// File: rtl/crossbar_trace_mon.sv
// Passive A-channel trace monitor: filtered, timestamped beats into a DEPTH-entry FIFO for a debug host.
// Latency 1 cycle from hit to t_valid; a hit against a full FIFO with no pop is dropped and counted, never stalls the crossbar.
module crossbar_trace_mon #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 64,
  parameter int CHIP_W  = 6,
  parameter int TS_W    = 32,
  parameter int CNT_W   = 16,
  parameter int VERBOSE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               a_opcode,
  input  logic [3:0]               a_source,
  input  logic [ADDR_W-1:0]        a_address,
  input  logic                     a_valid,
  input  logic                     a_ready,
  input  logic [CHIP_W-1:0]        chip_sel,
  input  logic [ADDR_W-1:0]        chip_addr,
  input  logic                     trace_en,
  input  logic                     filter_en,
  input  logic [CHIP_W-1:0]        filter_chip,
  input  logic                     clear,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic [TS_W-1:0]          t_ts,
  output logic [2:0]               t_opcode,
  output logic [3:0]               t_source,
  output logic [CHIP_W-1:0]        t_chip,
  output logic [ADDR_W-1:0]        t_addr,
  output logic [$clog2(DEPTH):0]   t_level,
  output logic [CNT_W-1:0]         cnt_match,
  output logic [CNT_W-1:0]         cnt_drop,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [2:0]        opcode;
    logic [3:0]        source;
    logic [CHIP_W-1:0] chip;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     level;
  logic [TS_W-1:0] ts;
  logic            hit, pop, full, push, drop;

  assign hit  = a_valid & a_ready & trace_en & (~filter_en | (chip_sel == filter_chip));
  assign full = (level == (PW+1)'(DEPTH));
  assign pop  = t_valid & t_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
  assign push = hit & (~full | pop);
  assign drop = hit & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt_match <= '0;
      cnt_drop  <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt_match <= '0;
      cnt_drop  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + (PW+1)'(1);
      else if (pop && !push) level <= level - (PW+1)'(1);
      if (hit && cnt_match != {CNT_W{1'b1}}) cnt_match <= cnt_match + CNT_W'(1);
      if (drop) begin
        if (cnt_drop != {CNT_W{1'b1}}) cnt_drop <= cnt_drop + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= '{ts, a_opcode, a_source, chip_sel, chip_addr};
  end

  // Head fields are forced to zero while empty so a reset reads back as all-zero.
  assign head     = mem[rd_ptr];
  assign t_valid  = (level != '0);
  assign t_level  = level;
  assign t_ts     = t_valid ? head.ts     : '0;
  assign t_opcode = t_valid ? head.opcode : '0;
  assign t_source = t_valid ? head.source : '0;
  assign t_chip   = t_valid ? head.chip   : '0;
  assign t_addr   = t_valid ? head.addr   : '0;

  logic unused_addr;
  assign unused_addr = ^a_address;

  generate
    if (VERBOSE != 0) begin : g_verbose
`ifndef SYNTHESIS
      always @(posedge clk) begin
        if (rst_n && hit && !clear)
          $display("%0t trace addr=%h chip=%0d chip_addr=%h %s",
                   $time, a_address, chip_sel, chip_addr, drop ? "drop" : "cap");
      end
`endif
    end
  endgenerate

endmodule
